uart_cmd_master: RTL and testbench
==================================

Name: uart_cmd_master

Overview:
- Host-side initiator for the system's UART command protocol: the opposite end of the frame-parsing system controller.
- Accepts one command request at a time (register write, register read, ALU with operands, ALU without operands).
- Serializes the command into the protocol byte sequence on a byte-stream port that feeds a UART transmitter.
- Collects response bytes from a UART receiver byte port and returns one result, or a timeout indication.

Parameters:
- DATA_WIDTH, 8, byte width of the frame and register data.
- ADDR_WIDTH, 4, register-file address width.
- FUN_WIDTH, 4, ALU function code width.
- TO_WIDTH, 16, width of the response timeout counter.
- TIMEOUT_CYCLES, 16'hFFFF, number of idle CLK cycles allowed before a response is declared lost.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command request valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_type  in  2  command type: 0 = RF_WR, 1 = RF_RD, 2 = ALU_OP, 3 = ALU_NOP.
- cmd_addr  in  ADDR_WIDTH  register address, used by RF_WR and RF_RD.
- cmd_data  in  DATA_WIDTH  write data for RF_WR; operand A for ALU_OP.
- cmd_opb  in  DATA_WIDTH  operand B for ALU_OP.
- cmd_fun  in  FUN_WIDTH  ALU function code, used by ALU_OP and ALU_NOP.
- tx_byte  out  DATA_WIDTH  byte to transmit.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  transmitter consumes tx_byte when tx_valid && tx_ready.
- rx_byte  in  DATA_WIDTH  received response byte.
- rx_valid  in  1  one-cycle strobe marking rx_byte valid.
- rsp_valid  out  1  one-cycle pulse: the command has completed.
- rsp_data  out  2*DATA_WIDTH  response data; RF_RD result in [7:0], upper byte zero.
- rsp_timeout  out  1  qualified by rsp_valid: response timed out.
- busy  out  1  high from command accept until the rsp_valid cycle inclusive.

Behaviour:
- Reset values: cmd_ready=0 during reset and 1 after; tx_valid=0, tx_byte=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0; state=IDLE; all counters=0.
- Frame encoding (bytes sent in this order):
  - RF_WR: AA, {0,addr}, data. No response bytes.
  - RF_RD: BB, {0,addr}. One response byte.
  - ALU_OP: CC, A, B, {0,fun}. Two response bytes, LSB first.
  - ALU_NOP: DD, {0,fun}. Two response bytes, LSB first.
- FSM states: IDLE, SEND, WAIT_RSP, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept: latch all cmd_* fields, set byte index=0, load frame length (3/2/4/2) and expected response count (0/1/2/2), go to SEND.
  - Accept is cycle 0; tx_valid=1 with the opcode byte in cycle 1.
- SEND:
  - tx_valid=1.
  - tx_byte must hold stable while tx_valid && !tx_ready.
  - On handshake: index+1. On the last byte's handshake, go to WAIT_RSP if expected count > 0, else DONE.
  - Minimum one byte per cycle when tx_ready is tied high.
- WAIT_RSP:
  - Timeout counter clears on entry and on every rx_valid, and increments otherwise.
  - Each rx_valid stores rx_byte: first byte into rsp_data[7:0], second into [15:8]. The received count increments.
  - After the final expected byte, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES, go to DONE with the timeout flag set. rsp_data keeps any partial bytes; unfilled bytes are 0.
  - If rx_valid and timeout occur in the same cycle, the byte wins and the counter clears.
- DONE:
  - One cycle: rsp_valid=1, rsp_timeout=flag, then go to IDLE.
  - rsp_data holds its value until the next accept, where it clears to 0.
- rx_valid outside WAIT_RSP is ignored, and extra bytes beyond the expected count are discarded.
- cmd_valid while not in IDLE is ignored; cmd_ready=0.
- RST asserted mid-operation: at the next edge all outputs take their reset values and any partial frame is abandoned. tx_valid may drop without a handshake.
- The timeout counter saturates and never wraps.

Decomposition:
- Package uart_cmd_pkg holds:
  - opcode constants: RF_WR_CMD=8'hAA, RF_RD_CMD=8'hBB, ALU_OP_CMD=8'hCC, ALU_NOP_CMD=8'hDD;
  - the cmd_type encoding;
  - the state encoding;
  - per-type frame-length and response-count constants.
- One natural sub-module, uart_cmd_frame_mux: combinational selection of tx_byte from the latched fields, cmd_type and byte index.
- FSM, counters and response assembly stay in the top.

Test Plan:
- RF_WR, addr=4'h5, data=8'h3C, tx_ready=1 → tx bytes AA,05,3C on cycles 1-3. rsp_valid on cycle 4 with rsp_timeout=0, rsp_data=0. No rx needed.
- RF_RD, addr=4'h2, reply rx_byte=8'h81 three cycles after the last tx byte → rsp_valid with rsp_data=16'h0081, rsp_timeout=0.
- ALU_OP A=8'h0A, B=8'h14, fun=4'h0, tx_ready toggling 1/0 → bytes CC,0A,14,00, each held stable while stalled. Replies 1E then 00 → rsp_data=16'h001E.
- ALU_NOP fun=4'h2, TIMEOUT_CYCLES=20, only one reply byte 8'h55 → rsp_valid 20 cycles after that byte with rsp_timeout=1, rsp_data=16'h0055.
- Second cmd_valid during busy, plus a stray rx_valid while in IDLE → both ignored; cmd_ready=0 throughout busy and the response is unaffected.
- RST pulsed during the 3rd byte of ALU_OP → next cycle tx_valid=0, busy=0, cmd_ready=1. A following RF_RD then completes normally.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - opcodes, command types, FSM states and frame shapes for the UART command master
package uart_cmd_pkg;

    localparam logic [7:0] RF_WR_CMD   = 8'hAA;
    localparam logic [7:0] RF_RD_CMD   = 8'hBB;
    localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
    localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

    typedef enum logic [1:0] {
        RF_WR   = 2'd0,
        RF_RD   = 2'd1,
        ALU_OP  = 2'd2,
        ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [2:0] LEN_RF_WR   = 3'd3;
    localparam logic [2:0] LEN_RF_RD   = 3'd2;
    localparam logic [2:0] LEN_ALU_OP  = 3'd4;
    localparam logic [2:0] LEN_ALU_NOP = 3'd2;

    localparam logic [1:0] RSP_RF_WR   = 2'd0;
    localparam logic [1:0] RSP_RF_RD   = 2'd1;
    localparam logic [1:0] RSP_ALU_OP  = 2'd2;
    localparam logic [1:0] RSP_ALU_NOP = 2'd2;

    function automatic logic [2:0] frame_len(input cmd_type_e t);
        case (t)
            RF_WR:   frame_len = LEN_RF_WR;
            RF_RD:   frame_len = LEN_RF_RD;
            ALU_OP:  frame_len = LEN_ALU_OP;
            default: frame_len = LEN_ALU_NOP;
        endcase
    endfunction

    function automatic logic [1:0] rsp_count(input cmd_type_e t);
        case (t)
            RF_WR:   rsp_count = RSP_RF_WR;
            RF_RD:   rsp_count = RSP_RF_RD;
            ALU_OP:  rsp_count = RSP_ALU_OP;
            default: rsp_count = RSP_ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_frame_mux.sv
// rtl/uart_cmd_frame_mux.sv - picks the outgoing frame byte from the latched command and byte index
module uart_cmd_frame_mux
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  cmd_type_e             cmd_type,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] opb,
    input  logic [FUN_WIDTH-1:0]  fun,
    input  logic [1:0]            idx,
    output logic [DATA_WIDTH-1:0] tx_byte
);

    always_comb begin
        tx_byte = '0;
        case (cmd_type)
            RF_WR: begin
                case (idx)
                    2'd0:    tx_byte = DATA_WIDTH'(RF_WR_CMD);
                    2'd1:    tx_byte = DATA_WIDTH'(addr);
                    default: tx_byte = data;
                endcase
            end
            RF_RD: begin
                if (idx == 2'd0) tx_byte = DATA_WIDTH'(RF_RD_CMD);
                else             tx_byte = DATA_WIDTH'(addr);
            end
            ALU_OP: begin
                case (idx)
                    2'd0:    tx_byte = DATA_WIDTH'(ALU_OP_CMD);
                    2'd1:    tx_byte = data;
                    2'd2:    tx_byte = opb;
                    default: tx_byte = DATA_WIDTH'(fun);
                endcase
            end
            default: begin
                if (idx == 2'd0) tx_byte = DATA_WIDTH'(ALU_NOP_CMD);
                else             tx_byte = DATA_WIDTH'(fun);
            end
        endcase
    end

endmodule

// File: rtl/uart_cmd_master.sv
// rtl/uart_cmd_master.sv - serialises one command frame to the UART and collects its response or timeout
module uart_cmd_master
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TO_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_type,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic [DATA_WIDTH-1:0]   cmd_opb,
    input  logic [FUN_WIDTH-1:0]    cmd_fun,
    output logic [DATA_WIDTH-1:0]   tx_byte,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   rx_byte,
    input  logic                    rx_valid,
    output logic                    rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_timeout,
    output logic                    busy
);

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                state;
    cmd_type_e             type_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] opb_q;
    logic [FUN_WIDTH-1:0]  fun_q;
    logic [1:0]            idx;
    logic [2:0]            len;
    logic [1:0]            rsp_exp;
    logic [1:0]            rsp_cnt;
    logic [TO_WIDTH-1:0]   to_cnt;
    logic [TO_WIDTH-1:0]   to_inc;
    logic [DATA_WIDTH-1:0] mux_byte;

    uart_cmd_frame_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .FUN_WIDTH (FUN_WIDTH)
    ) u_frame_mux (
        .cmd_type(type_q),
        .addr    (addr_q),
        .data    (data_q),
        .opb     (opb_q),
        .fun     (fun_q),
        .idx     (idx),
        .tx_byte (mux_byte)
    );

    // Byte is driven only while offering it, so it reads zero in reset and between frames.
    assign tx_byte = tx_valid ? mux_byte : '0;
    assign to_inc  = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            tx_valid    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            type_q      <= RF_WR;
            addr_q      <= '0;
            data_q      <= '0;
            opb_q       <= '0;
            fun_q       <= '0;
            idx         <= '0;
            len         <= '0;
            rsp_exp     <= '0;
            rsp_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        type_q    <= cmd_type_e'(cmd_type);
                        addr_q    <= cmd_addr;
                        data_q    <= cmd_data;
                        opb_q     <= cmd_opb;
                        fun_q     <= cmd_fun;
                        idx       <= '0;
                        len       <= frame_len(cmd_type_e'(cmd_type));
                        rsp_exp   <= rsp_count(cmd_type_e'(cmd_type));
                        rsp_cnt   <= '0;
                        rsp_data  <= '0;
                        cmd_ready <= 1'b0;
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (({1'b0, idx} + 3'd1) == len) begin
                            tx_valid <= 1'b0;
                            to_cnt   <= '0;
                            if (rsp_exp != 2'd0) begin
                                state <= WAIT_RSP;
                            end else begin
                                rsp_valid <= 1'b1;
                                state     <= DONE;
                            end
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                WAIT_RSP: begin
                    // A byte arriving on the timeout cycle still counts and restarts the wait.
                    if (rx_valid) begin
                        to_cnt  <= '0;
                        rsp_cnt <= rsp_cnt + 2'd1;
                        if (rsp_cnt == 2'd0) rsp_data[DATA_WIDTH-1:0] <= rx_byte;
                        else                 rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_byte;
                        if ((rsp_cnt + 2'd1) == rsp_exp) begin
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt      <= to_inc;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        to_cnt <= to_inc;
                    end
                end
                default: begin
                    rsp_valid   <= 1'b0;
                    rsp_timeout <= 1'b0;
                    busy        <= 1'b0;
                    cmd_ready   <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb/tb_uart_cmd_master.sv - randomized scoreboard bench for uart_cmd_master
module tb_uart_cmd_master;

    localparam int TO = 20;

    typedef struct {
        logic [15:0] data;
        logic        to;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [7:0]  cmd_opb;
    logic [3:0]  cmd_fun;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    int          checks;
    int          failures;
    int          cyc;
    int          tx_mode;
    logic        rx_live;
    logic [7:0]  exp_tx[$];
    rsp_t        exp_rsp[$];

    int          last_evt;
    int          acc_edge;
    logic        prev_stall;
    logic        prev_txv;
    logic [7:0]  prev_byte;
    logic [15:0] last_rsp;

    uart_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK        (clk),
        .RST        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_opb    (cmd_opb),
        .cmd_fun    (cmd_fun),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (bound expired or unexpected event)", name);
    endtask

    // Reference: frame bytes and the response implied by the reply bytes the bench will send.
    function automatic void model_cmd(input int t, input logic [3:0] a, input logic [7:0] d,
                                      input logic [7:0] b, input logic [3:0] f, input int nrep,
                                      input logic [7:0] r0, input logic [7:0] r1);
        rsp_t r;
        int   need;
        case (t)
            0: begin exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, a}); exp_tx.push_back(d); need = 0; end
            1: begin exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, a}); need = 1; end
            2: begin exp_tx.push_back(8'hCC); exp_tx.push_back(d); exp_tx.push_back(b);
                     exp_tx.push_back({4'h0, f}); need = 2; end
            default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, f}); need = 2; end
        endcase
        r.data = 16'h0000;
        if (nrep > 0 && need > 0) r.data[7:0]  = r0;
        if (nrep > 1 && need > 1) r.data[15:8] = r1;
        r.to = (nrep < need);
        exp_rsp.push_back(r);
    endfunction

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            exp_tx.delete();
            exp_rsp.delete();
            prev_stall = 1'b0;
            prev_txv   = 1'b0;
            last_rsp   = 16'h0000;
        end else begin
            if (prev_stall) chk("tx_hold_while_stalled", {tx_valid, tx_byte}, {1'b1, prev_byte});
            if (tx_valid && !prev_txv) begin
                chk("first_byte_latency", cyc, acc_edge);
                chk("rsp_data_clear_on_accept", rsp_data, 16'h0000);
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) fail_now("tx_unexpected_byte");
                else chk("tx_byte", tx_byte, exp_tx.pop_front());
                last_evt = cyc + 1;
            end
            if (rx_valid && rx_live) last_evt = cyc + 1;
            if (cmd_valid && cmd_ready) acc_edge = cyc + 1;
            if (busy) chk("cmd_ready_low_while_busy", cmd_ready, 1'b0);
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_timeout", rsp_timeout, e.to);
                    chk("rsp_latency", cyc - last_evt, e.to ? TO : 0);
                end
                last_rsp = rsp_data;
            end
            if (!busy) chk("rsp_data_hold", rsp_data, last_rsp);
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = tx_byte;
            prev_txv   = tx_valid;
        end
    end

    task automatic run_cmd(input int t, input logic [3:0] a, input logic [7:0] d, input logic [7:0] b,
                           input logic [3:0] f, input int nrep, input logic [7:0] r0, input logic [7:0] r1,
                           input int mode, input int first_gap, input bit extra, input bit junk);
        int n;
        int gap;
        tx_mode = mode;
        model_cmd(t, a, d, b, f, nrep, r0, r1);
        if (junk) begin
            rx_byte  = 8'($urandom);
            rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
        cmd_type  = 2'(t);
        cmd_addr  = a;
        cmd_data  = d;
        cmd_opb   = b;
        cmd_fun   = f;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) fail_now("accept_wait");
        @(posedge clk); #1;
        if (junk) begin
            cmd_type = 2'($urandom);
            cmd_addr = 4'($urandom);
            cmd_data = 8'($urandom);
            cmd_opb  = 8'($urandom);
            cmd_fun  = 4'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        n = 0;
        while (tx_valid && n < 400) begin @(posedge clk); #1; n++; end
        if (n >= 400) fail_now("tx_drain_wait");
        cmd_valid = 1'b0;
        for (int i = 0; i < nrep; i++) begin
            gap = (i == 0) ? first_gap : $urandom_range(0, 4);
            repeat (gap) begin @(posedge clk); #1; end
            rx_byte  = (i == 0) ? r0 : r1;
            rx_valid = 1'b1;
            rx_live  = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            rx_live  = 1'b0;
        end
        if (extra) begin
            rx_byte  = 8'($urandom);
            rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) fail_now("rsp_wait");
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    endtask

    initial begin
        int t;
        int need;
        int nrep;
        checks    = 0;
        failures  = 0;
        tx_mode   = 0;
        rx_live   = 1'b0;
        last_evt  = 0;
        acc_edge  = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 2'd0;
        cmd_addr  = 4'h0;
        cmd_data  = 8'h00;
        cmd_opb   = 8'h00;
        cmd_fun   = 4'h0;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 1'b0);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_tx_byte", tx_byte, 8'h00);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_data", rsp_data, 16'h0000);
        chk("reset_rsp_timeout", rsp_timeout, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", cmd_ready, 1'b1);

        run_cmd(0, 4'h5, 8'h3C, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0);
        run_cmd(1, 4'h2, 8'h00, 8'h00, 4'h0, 1, 8'h81, 8'h00, 0, 3, 1'b0, 1'b0);
        run_cmd(2, 4'h0, 8'h0A, 8'h14, 4'h0, 2, 8'h1E, 8'h00, 1, 1, 1'b0, 1'b0);
        run_cmd(3, 4'h0, 8'h00, 8'h00, 4'h2, 1, 8'h55, 8'h00, 0, 2, 1'b0, 1'b0);
        run_cmd(3, 4'h0, 8'h00, 8'h00, 4'h7, 0, 8'h00, 8'h00, 2, 0, 1'b0, 1'b0);
        run_cmd(1, 4'h9, 8'h00, 8'h00, 4'h0, 1, 8'hE7, 8'h00, 2, 1, 1'b1, 1'b1);

        // Abandon an ALU_OP frame while its third byte is on the wire.
        tx_mode = 0;
        model_cmd(2, 4'h0, 8'h11, 8'h22, 4'h3, 2, 8'h00, 8'h00);
        cmd_type = 2'd2; cmd_data = 8'h11; cmd_opb = 8'h22; cmd_fun = 4'h3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("third_byte_before_reset", {tx_valid, tx_byte}, {1'b1, 8'h22});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_tx_valid", tx_valid, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk("midreset_cmd_ready", cmd_ready, 1'b1);
        run_cmd(1, 4'h6, 8'h00, 8'h00, 4'h0, 1, 8'h3D, 8'h00, 0, 2, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            t    = $urandom_range(0, 3);
            need = (t == 0) ? 0 : (t == 1) ? 1 : 2;
            nrep = ($urandom_range(0, 5) == 0) ? $urandom_range(0, need) : need;
            run_cmd(t, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), nrep,
                    8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)) && (nrep == need), 1'($urandom_range(0, 3) == 0));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("tx_queue_drained", exp_tx.size(), 0);
        chk("rsp_queue_drained", exp_rsp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
